// File: rtl/fetch_issue_unit_pkg.sv
// Shared definitions for the fetch/issue slice.
// Contents: PC width and type, NOP encoding, fetch increment, default reset PC,
// and a helper that word-aligns an address.
package fetch_issue_unit_pkg;

    localparam int PC_W = 32;

    typedef logic [PC_W-1:0] pc_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam pc_t         PC_INC           = 32'd4;
    localparam pc_t         DEFAULT_RESET_PC = 32'h0000_0000;

    // Clears the byte-offset bits; reads every bit so no input is left dangling.
    function automatic pc_t align_pc(input pc_t addr);
        return addr & ~pc_t'(3);
    endfunction

endpackage

// File: rtl/fetch_issue_unit_if.sv
// Bus bundle between the fetch/issue stage and its neighbours
// (instruction memory, hazard detector, execute redirect, decode).
// Parameter: CNT_W - width of the event counters.
// Modports: master = fetch/issue stage, slave = surrounding pipeline/memory.
interface fetch_issue_unit_if
    import fetch_issue_unit_pkg::*;
#(
    parameter int CNT_W = 16
);
    // instruction memory side
    logic             imem_req_out;
    pc_t              imem_addr_out;
    logic             imem_wait_in;
    logic [31:0]      imem_data_in;
    // hazard detector / execute side
    logic             stall_in;
    logic             redirect_in;
    pc_t              redirect_pc_in;
    // issue side
    logic [31:0]      instr_out;
    pc_t              pc_out;
    logic             issue_valid_out;
    logic             kill_out;
    // event counters
    logic [CNT_W-1:0] stall_count_out;
    logic [CNT_W-1:0] redirect_count_out;

    modport master (
        output imem_req_out, imem_addr_out, instr_out, pc_out,
               issue_valid_out, kill_out, stall_count_out, redirect_count_out,
        input  imem_wait_in, imem_data_in, stall_in, redirect_in, redirect_pc_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, instr_out, pc_out,
               issue_valid_out, kill_out, stall_count_out, redirect_count_out,
        output imem_wait_in, imem_data_in, stall_in, redirect_in, redirect_pc_in
    );

endinterface

// File: rtl/fetch_issue_unit_sat_counter.sv
// Saturating event counter: counts inc_in pulses, sticks at all-ones.
// Ports: clk, reset (sync, active-high), inc_in (count enable),
//        count_out (current count).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_in,
    output logic [CNT_W-1:0] count_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_out <= '0;
        end else if (inc_in && (count_out != '1)) begin
            count_out <= count_out + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_issue_unit.sv
// Instruction fetch and issue stage.
// Drives a 1-cycle-latency instruction memory, presents one instruction per
// cycle to hazard detection/decode, replays on a registered stall (kill the
// decode slot, rewind to the stalled PC) and refetches on a redirect.
// Ports: clk, reset (sync, active-high), bus (fetch_issue_unit_if.master:
//        imem request/address/wait/data, stall/redirect inputs, issued
//        instruction/pc/valid/kill, stall and redirect counters).
module fetch_issue_unit
    import fetch_issue_unit_pkg::*;
#(
    parameter pc_t RESET_PC = DEFAULT_RESET_PC,
    parameter int  CNT_W    = 16
) (
    input logic                clk,
    input logic                reset,
    fetch_issue_unit_if.master bus
);

    pc_t  fpc;
    logic inflight;
    pc_t  inflight_pc;
    logic last_valid;
    pc_t  last_pc;

    logic stall_eff;
    logic issue_valid;

    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] redirect_count;

    // A stall against a bubble slot has nothing to replay; redirect overrides.
    always_comb begin
        stall_eff   = bus.stall_in & last_valid & ~bus.redirect_in;
        issue_valid = inflight & ~bus.redirect_in & ~stall_eff;
    end

    always_comb begin
        bus.kill_out           = stall_eff | (bus.redirect_in & last_valid);
        bus.issue_valid_out    = issue_valid;
        bus.instr_out          = issue_valid ? bus.imem_data_in : NOP_INSTR;
        bus.pc_out             = inflight_pc;
        bus.imem_req_out       = ~reset & ~bus.redirect_in & ~stall_eff;
        bus.imem_addr_out      = fpc;
        bus.stall_count_out    = stall_count;
        bus.redirect_count_out = redirect_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc        <= RESET_PC;
            inflight   <= 1'b0;
            last_valid <= 1'b0;
        end else begin
            last_valid <= issue_valid;
            last_pc    <= inflight_pc;
            if (bus.redirect_in) begin
                fpc      <= align_pc(bus.redirect_pc_in);
                inflight <= 1'b0;
            end else if (stall_eff) begin
                // Rewind to the slot decode just squashed.
                fpc      <= last_pc;
                inflight <= 1'b0;
            end else if (bus.imem_wait_in) begin
                inflight <= 1'b0;
            end else begin
                inflight    <= 1'b1;
                inflight_pc <= fpc;
                fpc         <= fpc + PC_INC;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (stall_eff),
        .count_out (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (bus.redirect_in),
        .count_out (redirect_count)
    );

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Bench for fetch_issue_unit: directed steps for reset release, stall replay,
// redirect, wait states, wrap and mid-stream reset, counter saturation, then
// a randomized phase, all checked against a reference model of the stage.
module tb_fetch_issue_unit;
    import fetch_issue_unit_pkg::*;

    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MAXC   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_issue_unit_if #(.CNT_W(CNT_W)) bus ();

    fetch_issue_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // reference model: fetch pointer, addresses awaiting issue, last slot
    bit          m_known = 1'b0;
    logic [31:0] m_fpc;
    logic [31:0] m_pend[$];
    bit          m_last_valid;
    logic [31:0] m_last_pc;
    int          m_scnt, m_rcnt;

    // inputs of the current cycle and the model's verdict on them
    bit          s_rst, s_stall, s_redir, s_wait, s_se;
    logic [31:0] s_rpc;
    bit          e_valid, e_kill, e_req;
    logic [31:0] e_pc;

    // memory model: word for the address accepted in the previous cycle
    bit          mem_v = 1'b0;
    logic [31:0] mem_a = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0] ^ 8'hC3, a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input bit rst, input bit stall, input bit redir,
                         input logic [31:0] rpc, input bit wt);
        s_rst = rst; s_stall = stall; s_redir = redir; s_rpc = rpc; s_wait = wt;
        reset              = rst;
        bus.stall_in       = stall;
        bus.redirect_in    = redir;
        bus.redirect_pc_in = rpc;
        bus.imem_wait_in   = wt;
        bus.imem_data_in   = mem_v ? mem_word(mem_a) : $urandom();
        #3;
        s_se    = stall && m_last_valid && !redir;
        e_kill  = s_se || (redir && m_last_valid);
        e_valid = (m_pend.size() != 0) && !redir && !s_se;
        e_pc    = (m_pend.size() != 0) ? m_pend[0] : 32'h0;
        e_req   = !rst && !redir && !s_se;
        if (m_known) begin
            chk("req", {31'b0, bus.imem_req_out}, {31'b0, e_req});
            if (e_req) chk("addr", bus.imem_addr_out, m_fpc);
            chk("valid", {31'b0, bus.issue_valid_out}, {31'b0, e_valid});
            chk("instr", bus.instr_out, e_valid ? mem_word(e_pc) : NOP_INSTR);
            if (e_valid) chk("pc", bus.pc_out, e_pc);
            chk("kill", {31'b0, bus.kill_out}, {31'b0, e_kill});
            chk("stall_cnt", 32'(bus.stall_count_out), 32'(m_scnt));
            chk("redir_cnt", 32'(bus.redirect_count_out), 32'(m_rcnt));
        end
    endtask

    task automatic tick();
        logic [31:0] tgt;
        mem_v = (bus.imem_req_out === 1'b1) && !s_wait;
        mem_a = bus.imem_addr_out;
        if (s_rst) begin
            m_fpc = RST_PC;
            m_pend.delete();
            m_last_valid = 1'b0;
            m_scnt = 0;
            m_rcnt = 0;
            m_known = 1'b1;
        end else begin
            tgt = m_last_pc;
            m_last_valid = e_valid;
            if (e_valid) m_last_pc = e_pc;
            if (s_redir) begin
                m_fpc = {s_rpc[31:2], 2'b00};
                m_pend.delete();
                if (m_rcnt < MAXC) m_rcnt++;
            end else if (s_se) begin
                m_fpc = tgt;
                m_pend.delete();
                if (m_scnt < MAXC) m_scnt++;
            end else if (s_wait) begin
                m_pend.delete();
            end else begin
                m_pend.delete();
                m_pend.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [CNT_W-1:0] ones;
        bit r, s, d, w;
        logic [31:0] rpc;
        ones = '1;

        // reset, then release with no waits
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_valid", {31'b0, bus.issue_valid_out}, 32'h0);
        chk("rst_instr", bus.instr_out, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req_out}, 32'h0);
        tick();
        idle(); chk("r1_addr", bus.imem_addr_out, 32'h0); tick();
        idle(); chk("r2_addr", bus.imem_addr_out, 32'h4); chk("r2_pc", bus.pc_out, 32'h0); tick();
        idle(); chk("r3_addr", bus.imem_addr_out, 32'h8); chk("r3_pc", bus.pc_out, 32'h4); tick();
        idle(); tick();
        idle(); tick();
        idle(); chk("pre_stall_pc", bus.pc_out, 32'h10); tick();

        // stall against 0x10, then a back-to-back stall that must be ignored
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_kill", {31'b0, bus.kill_out}, 32'h1);
        tick();
        apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall2_kill", {31'b0, bus.kill_out}, 32'h0);
        chk("stall2_addr", bus.imem_addr_out, 32'h10);
        tick();
        idle(); chk("replay_pc", bus.pc_out, 32'h10); chk("stall_cnt1", 32'(bus.stall_count_out), 32'h1); tick();

        // redirect with a simultaneous stall
        apply(1'b0, 1'b1, 1'b1, 32'h1002, 1'b0); tick();
        idle(); chk("redir_addr", bus.imem_addr_out, 32'h1000); tick();
        idle(); chk("redir_pc", bus.pc_out, 32'h1000);
        chk("redir_cnt1", 32'(bus.redirect_count_out), 32'h1);
        chk("redir_scnt", 32'(bus.stall_count_out), 32'h1);
        tick();

        // three wait states at 0x20
        apply(1'b0, 1'b0, 1'b1, 32'h20, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("wait_addr", bus.imem_addr_out, 32'h20);
            tick();
        end
        idle(); chk("wait_addr4", bus.imem_addr_out, 32'h20); tick();
        idle(); chk("wait_pc", bus.pc_out, 32'h20); tick();
        idle(); chk("wait_pc2", bus.pc_out, 32'h24); tick();

        // wrap at the top of the address space
        apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0); tick();
        idle(); tick();
        idle(); tick();
        idle(); chk("wrap_addr", bus.imem_addr_out, 32'h0); tick();
        idle(); chk("wrap_pc", bus.pc_out, 32'h0); tick();

        // reset mid-stream drops the returning data
        idle(); tick();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
        idle();
        chk("mid_rst_valid", {31'b0, bus.issue_valid_out}, 32'h0);
        chk("mid_rst_addr", bus.imem_addr_out, RST_PC);
        chk("mid_rst_scnt", 32'(bus.stall_count_out), 32'h0);
        tick();

        // stall counter saturation: 2^CNT_W + 3 effective stalls
        idle(); tick();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
            idle(); tick();
            idle(); tick();
        end
        idle(); chk("sat_scnt", 32'(bus.stall_count_out), 32'(ones)); tick();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(99) == 0);
            s   = ($urandom_range(3) == 0);
            d   = ($urandom_range(11) == 0);
            w   = ($urandom_range(4) == 0);
            rpc = $urandom();
            if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            apply(r, s, d, rpc, w);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_issue_unit.md
# fetch_issue_unit

Instruction fetch and issue stage that consumes the registered `stall` from the hazard detector and executes the replay it demands. It drives a 1-cycle-latency instruction memory and presents one instruction per cycle to the hazard detector and decode. On a stall it kills the offending decode slot and rewinds the PC. On a branch/jump redirect it flushes and refetches from the target.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `CNT_W`, default `16`: width of the saturating event counters.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `imem_req_out` out 1: fetch request this cycle.
- `imem_addr_out` out 32: fetch address; bits `[1:0]` are always 0.
- `imem_wait_in` in 1: memory did not accept this cycle's request.
- `imem_data_in` in 32: instruction for the address accepted in the previous cycle.
- `stall_in` in 1: hazard detector verdict on the slot issued in the previous cycle.
- `redirect_in` in 1: taken branch/jump from execute.
- `redirect_pc_in` in 32: redirect target.
- `instr_out` out 32: issued instruction; `32'h0` (NOP) when not valid.
- `pc_out` out 32: address of `instr_out`.
- `issue_valid_out` out 1: `instr_out` is a real instruction.
- `kill_out` out 1: decode must squash the slot it latched last cycle.
- `stall_count_out` out `CNT_W`: effective stalls, saturating.
- `redirect_count_out` out `CNT_W`: redirects, saturating.

## Operation

**State registers**
- `fpc`: next fetch address.
- `inflight` + `inflight_pc`: an address was accepted last cycle.
- `last_valid` + `last_pc`: registered copies of `issue_valid_out` and `pc_out`.
- Two counters.

**Derived signals**
- `stall_eff = stall_in & last_valid & !redirect_in`. A stall against a bubble slot is ignored.
- `kill_out = stall_eff | (redirect_in & last_valid)`.
- `issue_valid_out = inflight & !redirect_in & !stall_eff`.
- `instr_out = issue_valid_out ? imem_data_in : 0`.
- `pc_out = inflight_pc`, driven regardless of valid.
- `imem_req_out = !reset & !redirect_in & !stall_eff`.
- `imem_addr_out = fpc`.

**Next state, by priority**
1. `reset`: `fpc <= RESET_PC`; `inflight`, `last_valid`, and both counters clear.
2. `redirect_in`: `fpc <= {redirect_pc_in[31:2], 2'b00}`; `inflight <= 0`; `redirect_count` increments.
3. `stall_eff`: `fpc <= last_pc`; `inflight <= 0`; `stall_count` increments.
4. `imem_wait_in` (with request): `fpc` holds; `inflight <= 0`.
5. Otherwise: `inflight <= 1`; `inflight_pc <= fpc`; `fpc <= fpc + 4`, wrapping modulo 2^32.

**Common updates**
- `last_valid` and `last_pc` update every non-reset cycle from the outputs.
- Counters saturate at all-ones and never wrap.

## Timing

- Reset values of outputs: `issue_valid_out = 0`, `instr_out = 0`, `kill_out = 0`, `imem_req_out = 0`, counters = 0. `pc_out` is don't-care while not valid.
- First request: cycle R+1 with address `RESET_PC`, where R is the last reset cycle. First valid issue is at R+2.
- Throughput: 1 instruction per cycle with no wait, stall or redirect.
- Stall at cycle t, against the slot issued at t−1:
  - t: bubble, `kill_out = 1`.
  - t+1: refetch `last_pc`, bubble.
  - t+2: the stalled instruction is re-issued.
  - Net: the stalled instruction re-issues 3 cycles after its first issue, with 2 bubbles.
- Redirect at t: bubble at t and t+1, target issued at t+2. `kill_out` is asserted at t if the slot issued at t−1 was valid.
- `imem_wait_in` at t: the same address is re-presented at t+1, and t+1 is a bubble.
- Simultaneous redirect and stall: redirect wins, `stall_count` is unchanged.
- Back-to-back stalls: the stall at t+1 is ignored because `last_valid = 0`.
- Reset mid-operation: data returning in the cycle after reset is discarded because `inflight` is clear.
- Combinational paths: only `stall_in`/`redirect_in` to the outputs, and `imem_data_in` to `instr_out`. No combinational path from `imem_wait_in` to the outputs.

## Structure

**Shared package**
- `NOP_INSTR = 32'h0`.
- `PC_W = 32`.
- `PC_INC = 4`.
- Default `RESET_PC`.

**Sub-module:** `sat_counter` (parameter `CNT_W`; ports `clk`, `reset`, `inc_in`, `count_out`), instantiated twice. All fetch/issue logic stays in this module.

## Test plan

- **Reset release, no waits:** `imem_addr_out` = `0x0`, `0x4`, `0x8` on cycles R+1..R+3; `issue_valid_out` high from R+2 with `pc_out` = `0x0`, `0x4`.
- **Stall:** issue `0x10` at t−1, pulse `stall_in` at t → `kill_out = 1` at t, bubbles at t and t+1, `pc_out = 0x10` valid at t+2, `stall_count_out = 1`.
- **Redirect:** `redirect_in` to `0x1002` at t → fetch `0x1000` at t+1, issue `0x1000` at t+2; stall asserted in the same cycle is ignored; `redirect_count_out = 1`, `stall_count_out = 0`.
- **Wait states:** hold `imem_wait_in` for 3 cycles at address `0x20` → address held, 3 bubbles, then `0x20` issued in order with no address skipped.
- **Boundaries:** `stall_in` on the cycle after a stall produces no second rewind. `fpc = 0xFFFF_FFFC` wraps to `0x0`. Reset asserted mid-stream drops the returning data, and the next request is `RESET_PC`.
- **Saturation:** force `2^CNT_W + 3` stalls → `stall_count_out` is all-ones.
